distance_ip_s00_axi_slave: RTL and testbench

AXI4-Lite responder for distance_ip: four 32-bit read/write registers with byte strobes, accessed by the PS or the AXI4-Lite master BFM. Register contents and per-register write strobes are exported to the distance measurement core.

---
 rtl/distance_ip_s00_axi_slave.sv | 192 +++++++++++++++++++
 tb/tb_distance_ip_s00_axi_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/distance_ip_s00_axi_slave.sv
// AXI4-Lite register slave for distance_ip: four byte-strobed registers,
// exported to the measurement core together with a per-register commit pulse.
module distance_ip_s00_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [3:0]                        reg_wr
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic          r_awready;
    logic          r_aw_held;
    logic [1:0]    r_awidx;
    logic          r_wready;
    logic          r_w_held;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_slv [0:3];
    logic [3:0]    r_reg_wr;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_commit;
    logic w_aw_held_nxt;
    logic w_w_held_nxt;
    logic w_bvalid_nxt;
    logic w_rvalid_nxt;
    logic w_unused;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    assign w_aw_hs  = r_awready & S_AXI_AWVALID;
    assign w_w_hs   = r_wready & S_AXI_WVALID;
    assign w_ar_hs  = r_arready & S_AXI_ARVALID;
    // A commit waits for the previous response to be taken, so B never stacks.
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    // Next-state of the write holds and both response valids.
    always_comb begin
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_bvalid_nxt  = r_bvalid;
        w_rvalid_nxt  = r_rvalid;
        if (w_commit) begin
            w_aw_held_nxt = 1'b0;
            w_w_held_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
        end else begin
            w_aw_held_nxt = r_aw_held | w_aw_hs;
            w_w_held_nxt  = r_w_held | w_w_hs;
            w_bvalid_nxt  = r_bvalid & ~S_AXI_BREADY;
        end
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
        end else begin
            w_rvalid_nxt = r_rvalid & ~S_AXI_RREADY;
        end
    end

    // Write address/data capture and the handshake flags.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_aw_held <= 1'b0;
            r_awidx   <= 2'd0;
            r_wready  <= 1'b0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_awready <= ~w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_wready  <= ~w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_aw_hs) begin
                r_awidx <= S_AXI_AWADDR[3:2];
            end else begin
                r_awidx <= r_awidx;
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end else begin
                r_wdata <= r_wdata;
                r_wstrb <= r_wstrb;
            end
        end
    end

    // Register file update and the one-cycle commit pulse.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                r_slv[i] <= '0;
            end
            r_reg_wr <= 4'b0000;
        end else begin
            if (w_commit) begin
                r_slv[r_awidx] <= f_merge(r_slv[r_awidx], r_wdata, r_wstrb);
                r_reg_wr       <= f_onehot(r_awidx);
            end else begin
                r_reg_wr <= 4'b0000;
            end
        end
    end

    // Read data capture; sees the pre-write value if a commit lands on the same edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rdata <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rdata <= r_slv[S_AXI_ARADDR[3:2]];
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign reg_out       = {r_slv[3], r_slv[2], r_slv[1], r_slv[0]};
    assign reg_wr        = r_reg_wr;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_distance_ip_s00_axi_slave.sv
// Scoreboard bench for distance_ip_s00_axi_slave: directed scenarios plus
// randomized traffic checked against a word-array reference model.
module tb_distance_ip_s00_axi_slave;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, reg_wr;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;

    typedef struct { int idx; logic [31:0] val; } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [4];
    logic [31:0] rq [$];
    int          bq [$];
    wr_t         wq [$];
    bit          hold_b = 1'b0;
    bit          bp = 1'b0;
    logic [31:0] old_v;

    always #5 clk = ~clk;

    distance_ip_s00_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .reg_wr(reg_wr)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Byte-lane write semantics expressed as a mask over the whole word.
    function automatic logic [31:0] model_write(input logic [31:0] old_w, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (d & mask);
    endfunction

    // Response ready drivers, optionally randomized backpressure.
    initial begin
        bready = 1'b1;
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bready = hold_b ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected responses whenever the DUT completes one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        flag("b_unexpected");
                    end else begin
                        void'(bq.pop_front());
                        chk("bresp", 128'(bresp), 128'(2'b00));
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        flag("r_unexpected");
                    end else begin
                        chk("rdata", 128'(rdata), 128'(rq.pop_front()));
                        chk("rresp", 128'(rresp), 128'(2'b00));
                    end
                end
                if (reg_wr != 4'b0000) begin
                    if (wq.size() == 0) begin
                        flag("reg_wr_unexpected");
                    end else begin
                        e = wq.pop_front();
                        chk("reg_wr", 128'(reg_wr), 128'(4'b0001 << e.idx));
                        chk("reg_out_commit", 128'(reg_out[e.idx*32 +: 32]), 128'(e.val));
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((bq.size() != 0 || wq.size() != 0 || rq.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) flag("drain_timeout");
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awd, input int wd);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit awf, wf;
        int cyc = 0;
        int idx = int'(addr[3:2]);
        wr_t e;
        while (!(aw_done && w_done) && cyc < 60) begin
            if (!aw_done && cyc >= awd) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && cyc >= wd) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            @(negedge clk);
            if (aw_done && !w_done) chk("awready_held", 128'(awready), 128'(1'b0));
            if (w_done && !aw_done) chk("wready_held", 128'(wready), 128'(1'b0));
            awf = awvalid && awready;
            wf = wvalid && wready;
            @(posedge clk);
            #1;
            if (awf) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (wf) begin wvalid = 1'b0; w_done = 1'b1; end
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            flag("write_handshake_timeout");
        end else begin
            mem[idx] = model_write(mem[idx], data, strb);
            e.idx = idx;
            e.val = mem[idx];
            bq.push_back(1);
            wq.push_back(e);
        end
    endtask

    task automatic do_read(input logic [3:0] addr);
        bit f = 1'b0;
        int cyc = 0;
        wait_drain();
        arvalid = 1'b1;
        araddr = addr;
        while (!f && cyc < 60) begin
            @(negedge clk);
            f = arvalid && arready;
            @(posedge clk);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (f) rq.push_back(mem[int'(addr[3:2])]);
        else flag("read_handshake_timeout");
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = 4'h0; araddr = 4'h0; awprot = 3'b000; arprot = 3'b000;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        #1;
        chk("rst_awready", 128'(awready), 128'(1'b0));
        chk("rst_wready", 128'(wready), 128'(1'b0));
        chk("rst_arready", 128'(arready), 128'(1'b0));
        chk("rst_bvalid", 128'(bvalid), 128'(1'b0));
        chk("rst_rvalid", 128'(rvalid), 128'(1'b0));
        chk("rst_reg_out", reg_out, 128'h0);
        chk("rst_reg_wr", 128'(reg_wr), 128'(4'b0000));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_awready", 128'(awready), 128'(1'b1));
        chk("rel_wready", 128'(wready), 128'(1'b1));
        chk("rel_arready", 128'(arready), 128'(1'b1));

        // Concurrent AW+W: response exactly one edge after the handshake.
        do_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0);
        chk("lat_bvalid_early", 128'(bvalid), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("lat_bvalid", 128'(bvalid), 128'(1'b1));
        chk("lat_reg_wr", 128'(reg_wr), 128'(4'b0001));
        do_read(4'h0);

        do_write(4'h4, 32'hABCD0001, 4'hF, 0, 0);
        do_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0);
        do_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0);
        do_read(4'h4);
        do_read(4'h8);
        do_read(4'hC);
        wait_drain();
        chk("reg_out_top", 128'(reg_out[127:96]), 128'(32'hBEEF0011));

        // Data leads address by three cycles.
        do_write(4'h4, 32'h5A5A1234, 4'hF, 3, 0);
        do_read(4'h4);

        // Response stalled: second write accepted but commit deferred.
        wait_drain();
        hold_b = 1'b1;
        do_write(4'h0, 32'h11112222, 4'hF, 0, 0);
        old_v = mem[1];
        do_write(4'h4, 32'h33334444, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_bvalid", 128'(bvalid), 128'(1'b1));
            chk("stall_reg1", 128'(reg_out[63:32]), 128'(old_v));
        end
        @(posedge clk);
        #1;
        hold_b = 1'b0;
        do_read(4'h4);

        // Single-byte strobe and empty strobe.
        do_write(4'h8, 32'h12345678, 4'b0100, 0, 0);
        do_read(4'h9);
        wait_drain();
        chk("strb_byte2", 128'(reg_out[95:64]), 128'(32'hDE340011));
        do_write(4'h6, 32'hFFFFFFFF, 4'b0000, 1, 0);
        do_read(4'h4);

        // Randomized traffic with backpressure.
        bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(4'($urandom_range(0, 15)));
            end
        end
        wait_drain();
        bp = 1'b0;

        // Reset with AW held and W about to be offered.
        awvalid = 1'b1;
        awaddr = 4'h8;
        @(negedge clk);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_awready", 128'(awready), 128'(1'b0));
        @(posedge clk);
        #1;
        wvalid = 1'b1;
        wdata = 32'hCAFEF00D;
        wstrb = 4'hF;
        rst_n = 1'b0;
        #1;
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        @(negedge clk);
        chk("mid_rst_reg_out", reg_out, 128'h0);
        chk("mid_rst_bvalid", 128'(bvalid), 128'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_awready", 128'(awready), 128'(1'b1));
        chk("post_rst_wready", 128'(wready), 128'(1'b1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_bvalid", 128'(bvalid), 128'(1'b0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
